// File: rtl/stopwatch_timer_core.sv
// MM:SS BCD stopwatch / countdown core with prescaled step rate, clamped preset
// load, sticky expiry flag and a lap-capture FIFO whose head is always slot 0.
module stopwatch_timer_core #(
    parameter int TICK_DIV  = 1000,
    parameter int LAP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           run,
    input  logic                           dir_down,
    input  logic                           clear,
    input  logic                           load,
    input  logic [15:0]                    preset_bcd,
    input  logic                           lap,
    input  logic                           lap_pop,
    output logic [15:0]                    time_bcd,
    output logic [15:0]                    lap_bcd,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic                           lap_empty,
    output logic                           lap_full,
    output logic                           expired,
    output logic                           tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(LAP_DEPTH + 1);

    function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
        logic [15:0] r;
        r[15:12] = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
        r[11:8]  = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
        r[7:4]   = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
        r[3:0]   = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
        return r;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd5) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (v[11:8] != 4'd9) begin
                    r[11:8] = v[11:8] + 4'd1;
                end else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = (v[15:12] != 4'd9) ? v[15:12] + 4'd1 : 4'd0;
                end
            end
        end
        return r;
    endfunction

    // Caller guarantees v is non-zero, so the tens-of-minutes borrow never underflows.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    logic          clear_prev_r, load_prev_r, lap_prev_r, pop_prev_r;
    logic          clear_ev_s, load_ev_s, lap_ev_s, pop_ev_s, step_s;
    logic [PW-1:0] presc_r;
    logic [15:0]   time_nx_s;
    logic          expired_nx_s;
    logic [15:0]   fifo_r    [LAP_DEPTH];
    logic [15:0]   fifo_nx_s [LAP_DEPTH];
    logic [CW-1:0] cnt_nx_s;
    logic          do_pop_s, do_push_s;

    assign clear_ev_s = clear & ~clear_prev_r;
    assign load_ev_s  = load & ~load_prev_r;
    assign lap_ev_s   = lap & ~lap_prev_r;
    assign pop_ev_s   = lap_pop & ~pop_prev_r;
    assign step_s     = run & (presc_r == PW'(TICK_DIV - 1));
    assign lap_bcd    = fifo_r[0];

    // Next count and expiry: clear beats load beats step; expiry is sticky.
    always_comb begin
        time_nx_s    = time_bcd;
        expired_nx_s = expired;
        if (clear_ev_s) begin
            time_nx_s    = 16'h0000;
            expired_nx_s = 1'b0;
        end else if (load_ev_s) begin
            time_nx_s    = bcd_clamp(preset_bcd);
            expired_nx_s = 1'b0;
        end else if (step_s && dir_down) begin
            if (time_bcd == 16'h0000) begin
                expired_nx_s = 1'b1;
            end else begin
                time_nx_s    = bcd_dec(time_bcd);
                expired_nx_s = expired | (time_nx_s == 16'h0000);
            end
        end else if (step_s) begin
            time_nx_s = bcd_inc(time_bcd);
        end else begin
            time_nx_s = time_bcd;
        end
    end

    // Lap FIFO next state: unused slots stay zero so slot 0 doubles as lap_bcd.
    always_comb begin
        fifo_nx_s = fifo_r;
        cnt_nx_s  = lap_count;
        do_pop_s  = pop_ev_s && (lap_count != CW'(0));
        do_push_s = lap_ev_s && ((lap_count != CW'(LAP_DEPTH)) || do_pop_s);
        if (clear_ev_s) begin
            for (int i = 0; i < LAP_DEPTH; i++) fifo_nx_s[i] = 16'h0000;
            cnt_nx_s = CW'(0);
        end else begin
            if (do_pop_s) begin
                for (int i = 0; i < LAP_DEPTH - 1; i++) fifo_nx_s[i] = fifo_r[i + 1];
                fifo_nx_s[LAP_DEPTH - 1] = 16'h0000;
                cnt_nx_s = lap_count - CW'(1);
            end else begin
                cnt_nx_s = lap_count;
            end
            if (do_push_s) begin
                for (int i = 0; i < LAP_DEPTH; i++) begin
                    fifo_nx_s[i] = (CW'(i) == cnt_nx_s) ? time_bcd : fifo_nx_s[i];
                end
                cnt_nx_s = cnt_nx_s + CW'(1);
            end else begin
                cnt_nx_s = cnt_nx_s;
            end
        end
    end

    // State registers; edge-detect history resets high so held buttons stay quiet.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clear_prev_r <= 1'b1;
            load_prev_r  <= 1'b1;
            lap_prev_r   <= 1'b1;
            pop_prev_r   <= 1'b1;
            presc_r      <= PW'(0);
            time_bcd     <= 16'h0000;
            expired      <= 1'b0;
            tick         <= 1'b0;
            lap_count    <= CW'(0);
            lap_empty    <= 1'b1;
            lap_full     <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) fifo_r[i] <= 16'h0000;
        end else begin
            clear_prev_r <= clear;
            load_prev_r  <= load;
            lap_prev_r   <= lap;
            pop_prev_r   <= lap_pop;
            if (clear_ev_s || step_s) begin
                presc_r <= PW'(0);
            end else if (run) begin
                presc_r <= presc_r + PW'(1);
            end else begin
                presc_r <= presc_r;
            end
            time_bcd  <= time_nx_s;
            expired   <= expired_nx_s;
            tick      <= step_s;
            lap_count <= cnt_nx_s;
            lap_empty <= (cnt_nx_s == CW'(0));
            lap_full  <= (cnt_nx_s == CW'(LAP_DEPTH));
            fifo_r    <= fifo_nx_s;
        end
    end
endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// seconds-based reference model with a queue for the lap FIFO.
module tb_stopwatch_timer_core;
    localparam int TD = 4;
    localparam int LD = 2;

    logic        clk = 1'b0;
    logic        reset_n, run, dir_down, clear, load, lap, lap_pop;
    logic [15:0] preset_bcd;
    logic [15:0] time_bcd, lap_bcd;
    logic [1:0]  lap_count;
    logic        lap_empty, lap_full, expired, tick;

    int checks = 0;
    int errors = 0;

    // Reference model state: count kept as plain seconds 0..5999.
    int          m_sec = 0;
    int          m_presc = 0;
    bit          m_exp = 1'b0;
    bit          m_tick = 1'b0;
    bit          p_clear = 1'b1, p_load = 1'b1, p_lap = 1'b1, p_pop = 1'b1;
    logic [15:0] m_q[$];

    stopwatch_timer_core #(.TICK_DIV(TD), .LAP_DEPTH(LD)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .dir_down(dir_down),
        .clear(clear), .load(load), .preset_bcd(preset_bcd), .lap(lap),
        .lap_pop(lap_pop), .time_bcd(time_bcd), .lap_bcd(lap_bcd),
        .lap_count(lap_count), .lap_empty(lap_empty), .lap_full(lap_full),
        .expired(expired), .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int s);
        int mm = s / 60;
        int ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int clamp_sec(input logic [15:0] p);
        int mt = (int'(p[15:12]) > 9) ? 9 : int'(p[15:12]);
        int mo = (int'(p[11:8])  > 9) ? 9 : int'(p[11:8]);
        int st = (int'(p[7:4])   > 5) ? 5 : int'(p[7:4]);
        int so = (int'(p[3:0])   > 9) ? 9 : int'(p[3:0]);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    task automatic model_edge();
        bit          ce, le, pe, qe, stepping;
        logic [15:0] snap;
        if (!reset_n) begin
            m_sec = 0; m_presc = 0; m_exp = 1'b0; m_tick = 1'b0;
            m_q.delete();
            p_clear = 1'b1; p_load = 1'b1; p_lap = 1'b1; p_pop = 1'b1;
        end else begin
            ce = clear && !p_clear;
            le = load && !p_load;
            pe = lap && !p_lap;
            qe = lap_pop && !p_pop;
            stepping = run && (m_presc == TD - 1);
            m_tick = stepping;
            snap = to_bcd(m_sec);
            if (run) m_presc = (m_presc + 1) % TD;
            if (ce) begin
                m_presc = 0; m_sec = 0; m_exp = 1'b0;
            end else if (le) begin
                m_sec = clamp_sec(preset_bcd); m_exp = 1'b0;
            end else if (stepping) begin
                if (dir_down) begin
                    if (m_sec == 0) m_exp = 1'b1;
                    else begin
                        m_sec = m_sec - 1;
                        if (m_sec == 0) m_exp = 1'b1;
                    end
                end else begin
                    m_sec = (m_sec + 1) % 6000;
                end
            end
            if (ce) m_q.delete();
            else begin
                if (qe && m_q.size() > 0) void'(m_q.pop_front());
                if (pe && m_q.size() < LD) m_q.push_back(snap);
            end
            p_clear = clear; p_load = load; p_lap = lap; p_pop = lap_pop;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("time_bcd", time_bcd, to_bcd(m_sec));
        chk("lap_bcd", lap_bcd, (m_q.size() > 0) ? m_q[0] : 16'h0000);
        chk("lap_count", 16'(lap_count), 16'(m_q.size()));
        chk("lap_empty", 16'(lap_empty), 16'(m_q.size() == 0));
        chk("lap_full", 16'(lap_full), 16'(m_q.size() == LD));
        chk("expired", 16'(expired), 16'(m_exp));
        chk("tick", 16'(tick), 16'(m_tick));
    endtask

    task automatic wait_tick(input int bound);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (tick !== 1'b1 && n < bound);
        chk("tick_seen", 16'(tick), 16'd1);
    endtask

    task automatic run_to(input logic [15:0] target);
        int n = 0;
        run = 1'b1;
        while (time_bcd !== target && n < 200) begin
            cycle();
            n++;
        end
        run = 1'b0;
        chk("run_to", time_bcd, target);
    endtask

    initial begin
        int nt;
        int n;
        reset_n = 1'b0; run = 1'b0; dir_down = 1'b0; clear = 1'b0; load = 1'b0;
        lap = 1'b0; lap_pop = 1'b0; preset_bcd = 16'h0000;
        repeat (3) cycle();
        chk("rst_time", time_bcd, 16'h0000);
        chk("rst_empty", 16'(lap_empty), 16'd1);
        chk("rst_tick", 16'(tick), 16'd0);

        // 40 run cycles counting up.
        reset_n = 1'b1; run = 1'b1;
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (tick === 1'b1) nt++;
        end
        chk("up40_time", time_bcd, 16'h0010);
        chk("up40_ticks", 16'(nt), 16'd10);

        // Wrap 99:59 -> 00:00, then clamped load.
        run = 1'b0; preset_bcd = 16'h9959; load = 1'b1; cycle(); load = 1'b0;
        chk("load_9959", time_bcd, 16'h9959);
        run = 1'b1; wait_tick(8); run = 1'b0;
        chk("wrap_time", time_bcd, 16'h0000);
        chk("wrap_exp", 16'(expired), 16'd0);
        preset_bcd = 16'hFA7C; load = 1'b1; cycle(); load = 1'b0;
        chk("load_clamp", time_bcd, 16'h9959);

        // Countdown to expiry and hold.
        preset_bcd = 16'h0002; cycle(); load = 1'b1; cycle(); load = 1'b0;
        dir_down = 1'b1; run = 1'b1;
        wait_tick(8);
        chk("down_1", time_bcd, 16'h0001);
        chk("down_1_exp", 16'(expired), 16'd0);
        wait_tick(8);
        chk("down_0", time_bcd, 16'h0000);
        chk("down_0_exp", 16'(expired), 16'd1);
        wait_tick(8);
        chk("hold_0", time_bcd, 16'h0000);
        chk("hold_0_exp", 16'(expired), 16'd1);
        run = 1'b0; clear = 1'b1; cycle(); clear = 1'b0;
        chk("clear_exp", 16'(expired), 16'd0);
        dir_down = 1'b0;

        // Lap captures, overflow drop, pop, push+pop.
        run_to(16'h0003); lap = 1'b1; cycle(); lap = 1'b0;
        run_to(16'h0005); lap = 1'b1; cycle(); lap = 1'b0;
        run_to(16'h0007); lap = 1'b1; cycle(); lap = 1'b0;
        chk("lap_cnt2", 16'(lap_count), 16'd2);
        chk("lap_full", 16'(lap_full), 16'd1);
        chk("lap_head3", lap_bcd, 16'h0003);
        cycle();
        lap_pop = 1'b1; cycle(); lap_pop = 1'b0;
        chk("pop_head5", lap_bcd, 16'h0005);
        cycle();
        lap = 1'b1; lap_pop = 1'b1; cycle(); lap = 1'b0; lap_pop = 1'b0;
        chk("pp_cnt1", 16'(lap_count), 16'd1);
        chk("pp_head7", lap_bcd, 16'h0007);

        // Clear and load rising on a step edge.
        run = 1'b1; preset_bcd = 16'h1234; n = 0;
        while (m_presc != TD - 1 && n < 10) begin
            cycle();
            n++;
        end
        clear = 1'b1; load = 1'b1; cycle(); clear = 1'b0; load = 1'b0; run = 1'b0;
        chk("cl_time", time_bcd, 16'h0000);
        chk("cl_empty", 16'(lap_empty), 16'd1);
        chk("cl_tick", 16'(tick), 16'd1);

        // Lap held through reset release must not push.
        lap = 1'b1; reset_n = 1'b0; cycle(); cycle();
        reset_n = 1'b1; cycle(); cycle();
        chk("held_lap", 16'(lap_count), 16'd0);
        lap = 1'b0; cycle();

        // Pause mid-period keeps prescaler phase.
        run = 1'b1; cycle(); cycle();
        run = 1'b0; cycle(); cycle(); cycle();
        run = 1'b1; cycle();
        chk("pause_no_tick", 16'(tick), 16'd0);
        cycle();
        chk("pause_tick", 16'(tick), 16'd1);
        chk("pause_time", time_bcd, 16'h0001);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(299) != 0);
            run = ($urandom_range(7) != 0);
            if ($urandom_range(15) == 0) dir_down = ~dir_down;
            clear = ($urandom_range(39) == 0);
            load = ($urandom_range(19) == 0);
            lap = ($urandom_range(5) == 0);
            lap_pop = ($urandom_range(5) == 0);
            case ($urandom_range(3))
                0: preset_bcd = 16'h9959;
                1: preset_bcd = 16'h0001;
                default: preset_bcd = 16'($urandom());
            endcase
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_timer_core.md
# stopwatch_timer_core

Parametrised stopwatch/countdown core for the digital clock design. It counts MM:SS in BCD from a divided system clock, either up (stopwatch) or down (countdown with expiry flag), and keeps a small FIFO of lap captures. Its BCD outputs feed the existing 7-segment digit mux, and its control inputs come from the board push-buttons and switches. It generalises the fixed stopwatch with a configurable step rate, a direction mode, a preset load, and a lap buffer of configurable depth.

## Interface
- TICK_DIV, default 1000: clk cycles per count step; must be ≥ 2.
- LAP_DEPTH, default 4: lap FIFO entries; must be ≥ 1.
- clk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- run  in  1  level; counting is enabled while high.
- dir_down  in  1  level; 0 counts up, 1 counts down.
- clear  in  1  edge-detected; sets count to 00:00, zeroes the prescaler, and flushes the lap FIFO.
- load  in  1  edge-detected; loads preset_bcd into the count.
- preset_bcd  in  16  {Mt,Mo,St,So} BCD nibbles for load.
- lap  in  1  edge-detected; pushes the current count into the FIFO.
- lap_pop  in  1  edge-detected; discards the FIFO head.
- time_bcd  out  16  current count {Mt,Mo,St,So}.
- lap_bcd  out  16  FIFO head; 0 when empty.
- lap_count  out  $clog2(LAP_DEPTH+1)  number of entries in the FIFO.
- lap_empty, lap_full  out  1 each  FIFO status flags.
- expired  out  1  sticky flag: the countdown has reached 00:00.
- tick  out  1  one-cycle pulse on each count step.

## Operation
- Edge detect: each of clear, load, lap and lap_pop has a prev register, and an event is in & ~prev.
  - prev registers reset to 1, so an input held high through reset does not fire.
- Prescaler: counts 0..TICK_DIV-1 while run=1 and holds while run=0, so pause preserves phase.
  - At TICK_DIV-1 with run=1 it returns to 0; tick=1 and a step occurs.
- Up step: BCD increment with So 9→0 carrying to St, St 5→0 to Mo, Mo 9→0 to Mt. 99:59 wraps to 00:00, and expired is unaffected.
- Down step: BCD decrement with borrow (So 0→9, St 0→5, Mo 0→9).
  - A step landing on 00:00 sets expired.
  - A down step at 00:00 holds the count at 00:00 and sets expired; tick still pulses.
- Load: each nibble of preset_bcd is clamped: So, Mo, Mt >9 → 9; St >5 → 5. Load clears expired.
- Clear: sets count to 00:00, prescaler to 0, expired to 0, and empties the FIFO.
- Priority within one cycle: clear > load > step. A step coinciding with clear or load is discarded; tick still pulses.
- Lap push captures the time_bcd register value before any same-cycle step, clear or load.
- FIFO behaviour:
  - Push when full without pop: dropped, contents unchanged.
  - Pop when empty: ignored.
  - Push and pop together when non-empty: head removed, new entry appended, count unchanged.
  - Push and pop together when empty: push only.
- dir_down may change at any time and takes effect on the next step.

## Timing
- Reset state: time_bcd=0, lap_bcd=0, lap_count=0, lap_empty=1, lap_full=0, expired=0, tick=0, prescaler=0, FIFO pointers=0.
- All outputs are registered.
- Event latency: the effect is visible on outputs after the first clk edge that samples the input at 1 with prev=0, i.e. 1 cycle.
- Step period: exactly TICK_DIV cycles of run=1. tick is high for the one cycle in which the new time_bcd is first visible.
- lap_bcd, lap_count and the flags update in the same cycle as the push/pop effect.
- reset_n low mid-count or mid-FIFO returns everything to the reset state at the next edge. Inputs during reset are ignored.

## Test plan
Bench uses TICK_DIV=4, LAP_DEPTH=2.
- Reset, run=1, dir_down=0 for 40 cycles → time_bcd=0x0010, tick pulses every 4th cycle, 10 pulses total.
- Load preset 0x9959, run up 1 step → 0x0000, expired=0. Load 0xFA7C → time_bcd=0x9959 (clamped).
- Load 0x0002, dir_down=1, run 3 steps → 0x0001, 0x0000 with expired=1, then held at 0x0000. Clear → expired=0.
- Lap at 00:03, 00:05 and 00:07 → lap_count=2, lap_full=1, lap_bcd=0x0003 (third push dropped).
  - Pop → lap_bcd=0x0005. Push+pop together → count stays 1, lap_bcd=0x0007 captured.
- clear and load rising in the same cycle as a step → time_bcd=0x0000, FIFO empty, tick=1.
- Hold lap=1 through reset release → no push. Toggle run 1→0→1 mid-period → step occurs after a total of 4 run cycles.
